shift_ctrl_8: RTL
=================

# shift_ctrl_8

Upstream sequencer for the 8-bit load/shift register (`shift_reg_8`). It accepts parallel bytes over a valid/ready handshake and drives the register's `d_in`, `load` and `shift` inputs: one load cycle, then exactly `SHIFT_LEN` shift cycles, then an optional idle gap. It reports frame completion with a one-cycle `done` pulse and supports a `pause` input that freezes shifting mid-frame.

## Interface
Parameters:
- `WIDTH`, 8, data width of `in_data` and `d_in`.
- `SHIFT_LEN`, 8, number of shift cycles per frame; legal range 1..255.
- `GAP`, 0, number of idle cycles inserted after each frame; legal range 0..255.

Ports:
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  upstream byte available.
- `in_data`  input  WIDTH  upstream byte.
- `in_ready`  output  1  controller can accept a byte this cycle.
- `pause`  input  1  freezes the SHIFT state while high.
- `d_in`  output  WIDTH  data to the register; registered.
- `load`  output  1  register load strobe; registered.
- `shift`  output  1  register shift enable; registered.
- `busy`  output  1  high in any state other than IDLE.
- `done`  output  1  one-cycle pulse when a frame's final shift has been issued.

## Operation
States:
- IDLE: waiting for a byte.
- LOAD: drives the load strobe for one cycle.
- SHIFT: drives shift enables for `SHIFT_LEN` active cycles.
- GAP: idles for `GAP` cycles.

Handshake:
- A transfer occurs on any rising edge where `in_valid && in_ready` is true.
- `in_data` is captured on that edge.

Transitions:
- IDLE -> LOAD on a transfer.
- LOAD -> SHIFT always, after one cycle.
- SHIFT -> GAP when the bit counter reaches `SHIFT_LEN` and `GAP` > 0.
- SHIFT -> next state directly when the bit counter reaches `SHIFT_LEN` and `GAP` = 0.
- GAP -> next state when the gap counter reaches `GAP`.
- The next state is LOAD if a byte is pending (see Configuration); otherwise it is IDLE.

Outputs by state:
- `load` = 1 only in LOAD.
- `shift` = 1 in SHIFT when `pause` = 0 (see Timing for alignment).
- In SHIFT, `shift` = 0 while `pause` = 1, and the bit counter holds.
- `pause` has no effect in IDLE, LOAD or GAP.
- `d_in` is updated only on entry to LOAD and holds its value until the next LOAD.

Counters and width rules:
- Bit counter: 8 bits. Cleared on entry to SHIFT; increments on each cycle where `shift` = 1.
- Gap counter: 8 bits. Cleared on entry to GAP.
- The SHIFT exit comparison uses the post-increment value, so exactly `SHIFT_LEN` shift cycles are issued, never one more.

`done`:
- Asserted for exactly one cycle: the cycle after the last `shift` = 1 cycle.
- That cycle coincides with the first GAP cycle, the first IDLE cycle, or the next LOAD cycle.

Reset values:
- State IDLE.
- `d_in` = 0, `load` = 0, `shift` = 0, `done` = 0, `busy` = 0.
- Pending buffer empty.
- `in_ready` = 0 while `rst` is high.

Reset mid-frame:
- On the edge after `rst` rises, all outputs take their reset values.
- No `done` is emitted for the aborted frame.
- The pending byte is discarded.

## Timing
- Transfer at edge E0 -> `load` = 1 and `d_in` = byte during cycle E0..E1.
- `shift` = 1 from E1 through E1+`SHIFT_LEN`-1 (no pause).
- `done` = 1 in cycle E1+`SHIFT_LEN`.
- Frame period for back-to-back bytes is 1 + `SHIFT_LEN` + `GAP` cycles. A non-buffered build adds one extra IDLE cycle per frame.
- `pause` is sampled each cycle in SHIFT. Each paused cycle extends the frame by one cycle.
- `in_ready` is combinational from state and buffer occupancy only. It never depends on `in_valid`.

## Configuration
Macro `SHIFT_CTRL_8_BUF_EN`:
- Defined: adds a one-entry pending buffer.
  - `in_ready` = 1 whenever the buffer is empty, in any state.
  - A byte accepted in LOAD, SHIFT or GAP is held in the buffer. At frame end, state goes directly to LOAD with that byte, with no IDLE cycle.
  - A byte accepted in IDLE bypasses the buffer.
- Undefined: no buffer.
  - `in_ready` = (state == IDLE) && !`rst`.
  - Frame end always returns to IDLE.

## Test plan
1. Reset then single byte: `rst` high for 2 cycles, then transfer 8'h55 -> one `load` cycle with `d_in` = 8'h55, exactly 8 `shift` cycles, `done` pulse at transfer+9 cycles, `busy` low afterwards.
2. Pause: transfer 8'hA3, hold `pause` = 1 for 3 cycles after the 4th shift -> 8 shift cycles total, `done` delayed by 3 cycles, `load` never re-asserts.
3. Gap: `GAP` = 2, two back-to-back bytes 8'h0F, 8'hF0 -> second `load` 11 cycles after the first with `SHIFT_CTRL_8_BUF_EN` defined, 12 cycles without.
4. Backpressure: `in_valid` held high with data 8'h11, 8'h22, 8'h33 -> each byte loaded exactly once and in order. `in_ready` is low while the buffer is full (buffered build) or outside IDLE (non-buffered build).
5. Reset mid-frame: `rst` asserted after the 3rd shift of 8'hC3, with a pending byte 8'h99 -> next cycle all outputs zero, no `done`, and 8'h99 is never loaded.
6. Boundary: `SHIFT_LEN` = 1, `GAP` = 0, continuous stream -> `load` and `shift` alternate every cycle (buffered build), and `done` coincides with each subsequent `load`.

Source files
------------

// File: rtl/shift_ctrl_8.sv
// shift_ctrl_8: sequencer for shift_reg_8. Each byte produces one load, SHIFT_LEN shifts and GAP idle cycles.
// Latency: load is seen the cycle after the transfer edge, and done the cycle after the last shift.
// Backpressure: in_ready depends only on state and buffer occupancy. Pause freezes shifting with a one-cycle lag.
// Optional one-entry pending buffer: define SHIFT_CTRL_8_BUF_EN.
// shift is registered, so pause sampled at an edge suppresses the shift of the following cycle.
module shift_ctrl_8 #(
    parameter int WIDTH     = 8,
    parameter int SHIFT_LEN = 8,
    parameter int GAP       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             pause,
    output logic [WIDTH-1:0] d_in,
    output logic             load,
    output logic             shift,
    output logic             busy,
    output logic             done
);

    localparam logic [7:0] LEN8 = 8'(SHIFT_LEN);
    localparam logic [7:0] GAP8 = 8'(GAP);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       bit_cnt;
    logic [7:0]       gap_cnt;
    logic             xfer;
    logic             last_shift;
    logic             gap_end;
    logic             frame_end;
    logic             pending;
    logic [WIDTH-1:0] next_byte;
    logic             load_nxt;
    logic             shift_nxt;
    logic             done_nxt;
    logic [WIDTH-1:0] d_in_nxt;

    assign xfer       = in_valid && in_ready;
    // Exit compares the post-increment count, so exactly SHIFT_LEN shifts are issued.
    assign last_shift = (state == S_SHIFT) && shift && ((bit_cnt + 8'd1) == LEN8);
    assign gap_end    = (state == S_GAP) && ((gap_cnt + 8'd1) == GAP8);
    assign frame_end  = (last_shift && (GAP8 == 8'd0)) || gap_end;
    assign busy       = (state != S_IDLE);

`ifdef SHIFT_CTRL_8_BUF_EN
    logic             buf_vld;
    logic [WIDTH-1:0] buf_dat;

    assign in_ready  = !buf_vld && !rst;
    // A byte arriving on the frame-end edge goes straight to LOAD instead of the buffer.
    assign pending   = buf_vld || xfer;
    assign next_byte = buf_vld ? buf_dat : in_data;

    // Pending buffer: filled by mid-frame transfers and drained at frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_vld <= 1'b0;
            buf_dat <= '0;
        end else if (frame_end && buf_vld) begin
            buf_vld <= 1'b0;
        end else if (xfer && (state != S_IDLE) && !frame_end) begin
            buf_vld <= 1'b1;
            buf_dat <= in_data;
        end
    end
`else
    assign in_ready  = (state == S_IDLE) && !rst;
    assign pending   = 1'b0;
    assign next_byte = in_data;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (xfer) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (frame_end)       state_nxt = pending ? S_LOAD : S_IDLE;
                else if (last_shift) state_nxt = S_GAP;
            end
            S_GAP:   if (frame_end) state_nxt = pending ? S_LOAD : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        load_nxt  = (state_nxt == S_LOAD);
        shift_nxt = (state_nxt == S_SHIFT) && !((state == S_SHIFT) && pause);
        done_nxt  = last_shift;
        d_in_nxt  = d_in;
        if ((state_nxt == S_LOAD) && (state != S_LOAD)) d_in_nxt = next_byte;
    end

    // Output and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_in    <= '0;
            load    <= 1'b0;
            shift   <= 1'b0;
            done    <= 1'b0;
            bit_cnt <= 8'd0;
            gap_cnt <= 8'd0;
        end else begin
            d_in  <= d_in_nxt;
            load  <= load_nxt;
            shift <= shift_nxt;
            done  <= done_nxt;
            if ((state_nxt == S_SHIFT) && (state != S_SHIFT)) bit_cnt <= 8'd0;
            else if (shift)                                   bit_cnt <= bit_cnt + 8'd1;
            if ((state_nxt == S_GAP) && (state != S_GAP))     gap_cnt <= 8'd0;
            else if (state == S_GAP)                          gap_cnt <= gap_cnt + 8'd1;
        end
    end

endmodule
